tcm_axi_boot_loader: RTL and testbench

Boot sequencer for the TCM slave AXI port (`axi_t_*`) of `riscv_tcm_top`. It takes a word stream from a source such as a UART or ROM reader and writes it into TCM using single-beat AXI4 writes. It holds the CPU reset until the whole image is written with OKAY responses, then releases the core. It replaces the constant tie-offs on the TCM slave port and on `rst_cpu_i` in FPGA top levels.

---
 rtl/tcm_axi_boot_loader.sv | 149 ++++++++++++++
 tb/tb_tcm_axi_boot_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_axi_boot_loader.sv
// Boot sequencer: streams source words into TCM with single-beat AXI4 writes,
// holding the CPU in reset until every word has been acknowledged OKAY.
module tcm_axi_boot_loader #(
    parameter int         CNT_W  = 16,
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] word_count_i,
    input  logic             src_valid_i,
    input  logic [31:0]      src_data_i,
    output logic             src_ready_o,
    output logic             axi_awvalid_o,
    output logic [31:0]      axi_awaddr_o,
    output logic [3:0]       axi_awid_o,
    output logic [7:0]       axi_awlen_o,
    output logic [1:0]       axi_awburst_o,
    input  logic             axi_awready_i,
    output logic             axi_wvalid_o,
    output logic [31:0]      axi_wdata_o,
    output logic [3:0]       axi_wstrb_o,
    output logic             axi_wlast_o,
    input  logic             axi_wready_i,
    input  logic             axi_bvalid_i,
    input  logic [1:0]       axi_bresp_i,
    output logic             axi_bready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             rst_cpu_o,
    output logic [CNT_W-1:0] words_done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_RESP,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             aw_ok_q, aw_ok_d;
    logic             w_ok_q, w_ok_d;
    logic [31:0]      word_off;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^base_addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            count_q  <= '0;
            words_q  <= '0;
            aw_ok_q  <= 1'b0;
            w_ok_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            words_q  <= words_d;
            aw_ok_q  <= aw_ok_d;
            w_ok_q   <= w_ok_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        words_d  = words_q;
        aw_ok_d  = aw_ok_q;
        w_ok_d   = w_ok_q;
        word_off = 32'(words_q) << 2;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    base_d  = {base_addr_i[31:2], 2'b00};
                    count_d = word_count_i;
                    words_d = '0;
                    state_d = (word_count_i == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (src_valid_i) begin
                    wdata_d  = src_data_i;
                    awaddr_d = base_q + word_off;
                    aw_ok_d  = 1'b0;
                    w_ok_d   = 1'b0;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                // Each valid is low once its flag is set, so ready alone marks the handshake.
                aw_ok_d = aw_ok_q | axi_awready_i;
                w_ok_d  = w_ok_q | axi_wready_i;
                if (aw_ok_d && w_ok_d) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (axi_bvalid_i) begin
                    if (axi_bresp_i != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        words_d = words_q + 1'b1;
                        state_d = (words_d == count_q) ? S_DONE : S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign src_ready_o   = (state_q == S_FETCH);
    assign axi_awvalid_o = (state_q == S_WRITE) && !aw_ok_q;
    assign axi_wvalid_o  = (state_q == S_WRITE) && !w_ok_q;
    assign axi_bready_o  = (state_q == S_RESP);
    assign busy_o        = (state_q == S_FETCH) || (state_q == S_WRITE) || (state_q == S_RESP);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = (state_q == S_ERR);
    assign rst_cpu_o     = (state_q != S_DONE);
    assign words_done_o  = words_q;

    assign axi_awaddr_o  = awaddr_q;
    assign axi_awid_o    = AXI_ID;
    assign axi_awlen_o   = 8'd0;
    assign axi_awburst_o = 2'b01;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = 4'hF;
    assign axi_wlast_o   = 1'b1;

endmodule

// File: tb/tb_tcm_axi_boot_loader.sv
// Directed bench for tcm_axi_boot_loader: table of load scenarios driven through
// a small source/AXI slave model, plus reset sequences.
module tb_tcm_axi_boot_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] word_count_i;
    logic        src_valid_i;
    logic [31:0] src_data_i;
    logic        src_ready_o;
    logic        axi_awvalid_o;
    logic [31:0] axi_awaddr_o;
    logic [3:0]  axi_awid_o;
    logic [7:0]  axi_awlen_o;
    logic [1:0]  axi_awburst_o;
    logic        axi_awready_i;
    logic        axi_wvalid_o;
    logic [31:0] axi_wdata_o;
    logic [3:0]  axi_wstrb_o;
    logic        axi_wlast_o;
    logic        axi_wready_i;
    logic        axi_bvalid_i;
    logic [1:0]  axi_bresp_i;
    logic        axi_bready_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        rst_cpu_o;
    logic [15:0] words_done_o;

    tcm_axi_boot_loader #(.CNT_W(16), .AXI_ID(4'h0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .base_addr_i(base_addr_i), .word_count_i(word_count_i),
        .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
        .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o), .axi_awready_i(axi_awready_i),
        .axi_wvalid_o(axi_wvalid_o), .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o),
        .axi_wlast_o(axi_wlast_o), .axi_wready_i(axi_wready_i),
        .axi_bvalid_i(axi_bvalid_i), .axi_bresp_i(axi_bresp_i), .axi_bready_o(axi_bready_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rst_cpu_o(rst_cpu_o),
        .words_done_o(words_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [8*12-1:0] name;
        logic [31:0]     base;
        int              cnt;
        int              gap;       // FETCH cycles before the source offers a word
        int              aw_dly;    // WRITE cycles before AWREADY
        int              w_dly;     // WRITE cycles before WREADY
        int              b_dly;     // RESP cycles before BVALID
        int              err_word;  // word index answered with SLVERR, -1 for none
        bit              poke;      // pulse start_i mid-load
        int              exp_words;
        bit              exp_err;
        int              exp_cycles;
    } vec_t;

    vec_t vecs[9];

    int n_checks = 0;
    int n_errs   = 0;

    int          cfg_gap, cfg_aw, cfg_w, cfg_b, cfg_err, cur_v;
    int          aw_cnt, w_cnt, b_cnt, src_cnt, src_idx, b_idx;
    bit          run_active;
    logic        p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_awa, p_wd;
    logic [31:0] aw_log[$];
    logic [31:0] w_log[$];

    function automatic logic [31:0] data_of(input int v, input int i);
        if (v == 0) return 32'h11 * (i + 1);
        return {v[7:0], i[7:0], 16'hC0DE};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One cycle: check protocol rules on the settled outputs, then drive the model's next inputs.
    task automatic tick();
        @(negedge clk_i);
        if (run_active) begin
            if (src_ready_o) chk("fetch_quiet", {30'd0, axi_awvalid_o, axi_wvalid_o}, 32'd0);
            if (p_awv && !p_awr) begin
                chk("aw_hold", {31'd0, axi_awvalid_o}, 32'd1);
                chk("aw_addr_stable", axi_awaddr_o, p_awa);
            end
            if (p_wv && !p_wr) begin
                chk("w_hold", {31'd0, axi_wvalid_o}, 32'd1);
                chk("w_data_stable", axi_wdata_o, p_wd);
            end
            chk("rst_cpu_vs_done", {31'd0, rst_cpu_o}, {31'd0, !done_o});
        end
        p_awv = axi_awvalid_o; p_awa = axi_awaddr_o;
        p_wv  = axi_wvalid_o;  p_wd  = axi_wdata_o;
        if (axi_awvalid_o) begin
            axi_awready_i = (aw_cnt >= cfg_aw);
            aw_cnt++;
            if (axi_awready_i) aw_log.push_back(axi_awaddr_o);
        end else begin
            axi_awready_i = 1'b0; aw_cnt = 0;
        end
        if (axi_wvalid_o) begin
            axi_wready_i = (w_cnt >= cfg_w);
            w_cnt++;
            if (axi_wready_i) w_log.push_back(axi_wdata_o);
        end else begin
            axi_wready_i = 1'b0; w_cnt = 0;
        end
        p_awr = axi_awready_i; p_wr = axi_wready_i;
        if (src_ready_o) begin
            src_valid_i = (src_cnt >= cfg_gap);
            src_cnt++;
            src_data_i = data_of(cur_v, src_idx);
            if (src_valid_i) src_idx++;
        end else begin
            src_valid_i = 1'b0; src_cnt = 0;
        end
        if (axi_bready_o) begin
            axi_bvalid_i = (b_cnt >= cfg_b);
            b_cnt++;
            axi_bresp_i = (b_idx == cfg_err) ? 2'b10 : 2'b00;
            if (axi_bvalid_i) b_idx++;
        end else begin
            axi_bvalid_i = 1'b0; axi_bresp_i = 2'b00; b_cnt = 0;
        end
    endtask

    task automatic check_reset(input string pfx);
        chk({pfx, "/awvalid"}, {31'd0, axi_awvalid_o}, 32'd0);
        chk({pfx, "/wvalid"}, {31'd0, axi_wvalid_o}, 32'd0);
        chk({pfx, "/src_ready"}, {31'd0, src_ready_o}, 32'd0);
        chk({pfx, "/bready"}, {31'd0, axi_bready_o}, 32'd0);
        chk({pfx, "/busy"}, {31'd0, busy_o}, 32'd0);
        chk({pfx, "/done"}, {31'd0, done_o}, 32'd0);
        chk({pfx, "/err"}, {31'd0, err_o}, 32'd0);
        chk({pfx, "/rst_cpu"}, {31'd0, rst_cpu_o}, 32'd1);
        chk({pfx, "/words_done"}, {16'd0, words_done_o}, 32'd0);
        chk({pfx, "/awaddr"}, axi_awaddr_o, 32'd0);
        chk({pfx, "/wdata"}, axi_wdata_o, 32'd0);
    endtask

    task automatic run_vec(input int v);
        vec_t        t;
        int          n;
        int          nwr;
        bit          fin;
        string       nm;
        logic [31:0] exp_addr;
        t = vecs[v];
        nm = $sformatf("%0s", t.name);
        cfg_gap = t.gap; cfg_aw = t.aw_dly; cfg_w = t.w_dly; cfg_b = t.b_dly; cfg_err = t.err_word;
        cur_v = v; src_idx = 0; b_idx = 0;
        aw_log.delete(); w_log.delete();
        base_addr_i  = t.base;
        word_count_i = 16'(t.cnt);
        start_i      = 1'b1;
        run_active   = 1'b1;
        n = 0; fin = 0;
        while (!fin && n < 400) begin
            tick();
            n++;
            if (n == 1) begin
                start_i = 1'b0;
                base_addr_i = 32'hDEAD_BEE0;
                word_count_i = 16'd9;
                if (t.cnt > 0) begin
                    chk({nm, "/start_src_ready"}, {31'd0, src_ready_o}, 32'd1);
                    chk({nm, "/start_busy"}, {31'd0, busy_o}, 32'd1);
                    chk({nm, "/start_flags"}, {29'd0, done_o, err_o, rst_cpu_o}, 32'd1);
                end
            end
            if (t.poke && n == 2) start_i = 1'b1;
            if (t.poke && n == 3) start_i = 1'b0;
            if (done_o || err_o) fin = 1;
        end
        run_active = 1'b0;
        chk({nm, "/cycles"}, n, t.exp_cycles);
        chk({nm, "/done"}, {31'd0, done_o}, {31'd0, !t.exp_err});
        chk({nm, "/err"}, {31'd0, err_o}, {31'd0, t.exp_err});
        chk({nm, "/rst_cpu"}, {31'd0, rst_cpu_o}, {31'd0, t.exp_err});
        chk({nm, "/busy"}, {31'd0, busy_o}, 32'd0);
        chk({nm, "/words_done"}, {16'd0, words_done_o}, t.exp_words);
        nwr = t.exp_err ? t.err_word + 1 : t.cnt;
        chk({nm, "/aw_count"}, aw_log.size(), nwr);
        chk({nm, "/w_count"}, w_log.size(), nwr);
        for (int i = 0; i < nwr && i < aw_log.size() && i < w_log.size(); i++) begin
            exp_addr = {t.base[31:2], 2'b00} + 32'(4 * i);
            chk($sformatf("%s/addr%0d", nm, i), aw_log[i], exp_addr);
            chk($sformatf("%s/data%0d", nm, i), w_log[i], data_of(v, i));
        end
    endtask

    initial begin
        vecs[0] = '{"basic4",    32'h0000_0000, 4, 0, 0, 0, 0, -1, 1'b0, 4, 1'b0, 13};
        vecs[1] = '{"aw_late",   32'h0000_0100, 2, 0, 3, 0, 0, -1, 1'b1, 2, 1'b0, 13};
        vecs[2] = '{"w_late",    32'h0000_0104, 2, 0, 0, 3, 0, -1, 1'b0, 2, 1'b0, 13};
        vecs[3] = '{"both_late", 32'h0000_0200, 2, 0, 2, 2, 0, -1, 1'b0, 2, 1'b0, 11};
        vecs[4] = '{"stall",     32'h0000_0400, 3, 5, 0, 0, 2, -1, 1'b0, 3, 1'b0, 31};
        vecs[5] = '{"slverr",    32'h0000_0800, 4, 0, 0, 0, 0,  2, 1'b0, 2, 1'b1, 10};
        vecs[6] = '{"restart",   32'h0000_0800, 4, 0, 0, 0, 0, -1, 1'b0, 4, 1'b0, 13};
        vecs[7] = '{"zero",      32'h0000_0900, 0, 0, 0, 0, 0, -1, 1'b0, 0, 1'b0, 1};
        vecs[8] = '{"wrap",      32'hFFFF_FFFE, 2, 0, 0, 0, 0, -1, 1'b0, 2, 1'b0, 7};

        rst_ni = 1'b0; start_i = 1'b0; base_addr_i = '0; word_count_i = '0;
        src_valid_i = 1'b0; src_data_i = '0;
        axi_awready_i = 1'b0; axi_wready_i = 1'b0; axi_bvalid_i = 1'b0; axi_bresp_i = 2'b00;
        cfg_gap = 0; cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_err = -1; cur_v = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; src_cnt = 0; src_idx = 0; b_idx = 0;
        run_active = 1'b0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_awa = '0; p_wd = '0;

        repeat (3) tick();
        check_reset("reset");
        chk("const_awid", {28'd0, axi_awid_o}, 32'h0);
        chk("const_awlen", {24'd0, axi_awlen_o}, 32'h0);
        chk("const_awburst", {30'd0, axi_awburst_o}, 32'h1);
        chk("const_wstrb", {28'd0, axi_wstrb_o}, 32'hF);
        chk("const_wlast", {31'd0, axi_wlast_o}, 32'h1);
        rst_ni = 1'b1;
        tick();
        chk("idle_rst_cpu", {31'd0, rst_cpu_o}, 32'd1);

        for (int v = 0; v < 9; v++) run_vec(v);

        // Reset while both AW and W are stuck waiting for ready.
        cfg_gap = 0; cfg_aw = 20; cfg_w = 20; cfg_b = 0; cfg_err = -1; cur_v = 3; src_idx = 0; b_idx = 0;
        base_addr_i = 32'h0000_0300; word_count_i = 16'd2; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        chk("midwrite/awvalid_pre", {31'd0, axi_awvalid_o}, 32'd1);
        chk("midwrite/wvalid_pre", {31'd0, axi_wvalid_o}, 32'd1);
        rst_ni = 1'b0;
        tick();
        check_reset("midwrite_reset");
        rst_ni = 1'b1;
        tick();
        chk("after_reset_busy", {31'd0, busy_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
